// File: rtl/isp_awb_stat_pkg.sv
// Shared types for the AWB statistics block: CFA orders, colour codes, FSM states
// and the Bayer phase-to-colour mapping.
package isp_awb_stat_pkg;

    localparam int BAYER_RGGB = 0;
    localparam int BAYER_GRBG = 1;
    localparam int BAYER_GBRG = 2;
    localparam int BAYER_BGGR = 3;

    localparam int STAT_W = 32;

    typedef enum logic [1:0] {
        CLR_R = 2'd0,
        CLR_G = 2'd1,
        CLR_B = 2'd2
    } colour_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_PUB  = 2'd2
    } awb_state_e;

    // The BAYER code is the {row,col} quad position of R; B sits diagonally opposite.
    function automatic colour_e bayer_colour(input logic [1:0] bayer, input logic row,
                                             input logic col);
        logic [1:0] pos;
        pos = {row, col};
        if (pos == bayer) return CLR_R;
        if (pos == ~bayer) return CLR_B;
        return CLR_G;
    endfunction

endpackage

// File: rtl/isp_awb_stat_if.sv
// Raw Bayer input stream plus the published per-frame statistics.
// Handshake: no back-pressure; a pixel is taken on every pclk with in_href=1,
// and stat_done is a single-cycle strobe qualifying pix_cnt/sum_*.
interface isp_awb_stat_if
    import isp_awb_stat_pkg::*;
#(
    parameter int BITS = 8
) ();

    logic              in_vsync;
    logic              in_href;
    logic [BITS-1:0]   in_raw;
    logic              stat_done;
    logic [STAT_W-1:0] pix_cnt;
    logic [STAT_W-1:0] sum_r;
    logic [STAT_W-1:0] sum_g;
    logic [STAT_W-1:0] sum_b;

    modport master (
        output in_vsync, in_href, in_raw,
        input  stat_done, pix_cnt, sum_r, sum_g, sum_b
    );

    modport slave (
        input  in_vsync, in_href, in_raw,
        output stat_done, pix_cnt, sum_r, sum_g, sum_b
    );

endinterface

// File: rtl/isp_awb_stat_sat_acc.sv
// Saturating accumulator: clr has priority over en; the sum sticks at all-ones
// instead of wrapping.
module isp_awb_stat_sat_acc #(
    parameter int W  = 32,
    parameter int DW = 8
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [W-1:0]  q
);

    logic [W-1:0] q_q, q_d;
    logic [W:0]   sum;

    always_comb begin
        sum = {1'b0, q_q} + (W+1)'(din);
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/isp_awb_stat.sv
// Per-frame R/G/B sum collector for AWB. Frames are delimited by the vsync rising
// edge; results are published one cycle after capture with a stat_done strobe.
module isp_awb_stat
    import isp_awb_stat_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int BAYER    = 0,
    parameter int ACC_BITS = 32
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          enable,
    isp_awb_stat_if.slave vid,
    output awb_state_e    dbg_state
);

    localparam logic [1:0] BAYER_SEL = 2'(BAYER);

    logic                vs_q, vs_d, vs_dly_q, vs_dly_d;
    logic                hr_q, hr_d, hr_dly_q, hr_dly_d;
    logic [BITS-1:0]     raw_q, raw_d;
    logic                col_q, col_d, row_q, row_d;
    awb_state_e          state_q, state_d;
    logic                en_lat_q, en_lat_d;
    logic [ACC_BITS-1:0] acc_cnt, acc_r, acc_g, acc_b;
    logic [ACC_BITS-1:0] cap_cnt_q, cap_cnt_d, cap_r_q, cap_r_d;
    logic [ACC_BITS-1:0] cap_g_q, cap_g_d, cap_b_q, cap_b_d;
    logic                stat_done_q, stat_done_d;
    logic [STAT_W-1:0]   pix_cnt_q, pix_cnt_d, sum_r_q, sum_r_d;
    logic [STAT_W-1:0]   sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic                vs_rise, hr_fall, armed, pub_ok, acc_en;
    colour_e             colour;

    always_comb begin
        vs_d     = vid.in_vsync;
        hr_d     = vid.in_href;
        raw_d    = vid.in_raw;
        vs_dly_d = vs_q;
        hr_dly_d = hr_q;

        vs_rise = vs_q & ~vs_dly_q;
        hr_fall = hr_dly_q & ~hr_q;
        armed   = (state_q != ST_IDLE);
        pub_ok  = armed & en_lat_q & (acc_cnt != '0);
        // A pixel coinciding with the frame edge is dropped, not carried into the next frame.
        acc_en  = hr_q & armed & ~vs_rise;
        colour  = bayer_colour(BAYER_SEL, row_q, col_q);

        col_d = (vs_rise || !hr_q) ? 1'b0 : ~col_q;
        row_d = row_q;
        if (vs_rise) begin
            row_d = 1'b0;
        end else if (hr_fall) begin
            row_d = ~row_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_lat_d  = en_lat_q;
        cap_cnt_d = cap_cnt_q;
        cap_r_d   = cap_r_q;
        cap_g_d   = cap_g_q;
        cap_b_d   = cap_b_q;

        unique case (state_q)
            ST_IDLE: if (vs_rise) state_d = ST_ACC;
            ST_ACC:  if (vs_rise) state_d = pub_ok ? ST_PUB : ST_ACC;
            ST_PUB:  state_d = (vs_rise && pub_ok) ? ST_PUB : ST_ACC;
            default: state_d = ST_IDLE;
        endcase

        if (vs_rise) begin
            en_lat_d = enable;
        end
        if (vs_rise && pub_ok) begin
            cap_cnt_d = acc_cnt;
            cap_r_d   = acc_r;
            cap_g_d   = acc_g;
            cap_b_d   = acc_b;
        end
    end

    // Green is halved so all three sums are per 2x2 quad.
    always_comb begin
        stat_done_d = (state_q == ST_PUB);
        pix_cnt_d   = pix_cnt_q;
        sum_r_d     = sum_r_q;
        sum_g_d     = sum_g_q;
        sum_b_d     = sum_b_q;
        if (state_q == ST_PUB) begin
            pix_cnt_d = STAT_W'(cap_cnt_q);
            sum_r_d   = STAT_W'(cap_r_q);
            sum_g_d   = STAT_W'(cap_g_q >> 1);
            sum_b_d   = STAT_W'(cap_b_q);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            vs_dly_q    <= 1'b0;
            hr_q        <= 1'b0;
            hr_dly_q    <= 1'b0;
            raw_q       <= '0;
            col_q       <= 1'b0;
            row_q       <= 1'b0;
            state_q     <= ST_IDLE;
            en_lat_q    <= 1'b0;
            cap_cnt_q   <= '0;
            cap_r_q     <= '0;
            cap_g_q     <= '0;
            cap_b_q     <= '0;
            stat_done_q <= 1'b0;
            pix_cnt_q   <= '0;
            sum_r_q     <= '0;
            sum_g_q     <= '0;
            sum_b_q     <= '0;
        end else begin
            vs_q        <= vs_d;
            vs_dly_q    <= vs_dly_d;
            hr_q        <= hr_d;
            hr_dly_q    <= hr_dly_d;
            raw_q       <= raw_d;
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            en_lat_q    <= en_lat_d;
            cap_cnt_q   <= cap_cnt_d;
            cap_r_q     <= cap_r_d;
            cap_g_q     <= cap_g_d;
            cap_b_q     <= cap_b_d;
            stat_done_q <= stat_done_d;
            pix_cnt_q   <= pix_cnt_d;
            sum_r_q     <= sum_r_d;
            sum_g_q     <= sum_g_d;
            sum_b_q     <= sum_b_d;
        end
    end

    isp_awb_stat_sat_acc #(.W(ACC_BITS), .DW(BITS)) u_acc_r (
        .pclk(pclk), .rst_n(rst_n), .clr(vs_rise),
        .en(acc_en && colour == CLR_R), .din(raw_q), .q(acc_r)
    );

    isp_awb_stat_sat_acc #(.W(ACC_BITS), .DW(BITS)) u_acc_g (
        .pclk(pclk), .rst_n(rst_n), .clr(vs_rise),
        .en(acc_en && colour == CLR_G), .din(raw_q), .q(acc_g)
    );

    isp_awb_stat_sat_acc #(.W(ACC_BITS), .DW(BITS)) u_acc_b (
        .pclk(pclk), .rst_n(rst_n), .clr(vs_rise),
        .en(acc_en && colour == CLR_B), .din(raw_q), .q(acc_b)
    );

    isp_awb_stat_sat_acc #(.W(ACC_BITS), .DW(1)) u_acc_cnt (
        .pclk(pclk), .rst_n(rst_n), .clr(vs_rise),
        .en(acc_en && colour == CLR_R), .din(1'b1), .q(acc_cnt)
    );

    assign vid.stat_done = stat_done_q;
    assign vid.pix_cnt   = pix_cnt_q;
    assign vid.sum_r     = sum_r_q;
    assign vid.sum_g     = sum_g_q;
    assign vid.sum_b     = sum_b_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_isp_awb_stat.sv
// Bench for isp_awb_stat: one stream feeds RGGB, BGGR and 12-bit-accumulator
// instances; a frame-level model predicts each published result.
module tb_isp_awb_stat;
    import isp_awb_stat_pkg::*;

    localparam int NDUT = 3;

    logic       pclk;
    logic       rst_n;
    logic       enable;
    logic       drv_vsync;
    logic       drv_href;
    logic [7:0] drv_raw;

    int checks = 0;
    int errors = 0;

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #600000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    isp_awb_stat_if #(.BITS(8)) vif0 ();
    isp_awb_stat_if #(.BITS(8)) vif1 ();
    isp_awb_stat_if #(.BITS(8)) vif2 ();

    assign vif0.in_vsync = drv_vsync;
    assign vif0.in_href  = drv_href;
    assign vif0.in_raw   = drv_raw;
    assign vif1.in_vsync = drv_vsync;
    assign vif1.in_href  = drv_href;
    assign vif1.in_raw   = drv_raw;
    assign vif2.in_vsync = drv_vsync;
    assign vif2.in_href  = drv_href;
    assign vif2.in_raw   = drv_raw;

    awb_state_e  st_a   [NDUT];
    logic        done_a [NDUT];
    logic [31:0] cnt_a  [NDUT];
    logic [31:0] r_a    [NDUT];
    logic [31:0] g_a    [NDUT];
    logic [31:0] b_a    [NDUT];

    assign done_a[0] = vif0.stat_done;
    assign cnt_a[0]  = vif0.pix_cnt;
    assign r_a[0]    = vif0.sum_r;
    assign g_a[0]    = vif0.sum_g;
    assign b_a[0]    = vif0.sum_b;
    assign done_a[1] = vif1.stat_done;
    assign cnt_a[1]  = vif1.pix_cnt;
    assign r_a[1]    = vif1.sum_r;
    assign g_a[1]    = vif1.sum_g;
    assign b_a[1]    = vif1.sum_b;
    assign done_a[2] = vif2.stat_done;
    assign cnt_a[2]  = vif2.pix_cnt;
    assign r_a[2]    = vif2.sum_r;
    assign g_a[2]    = vif2.sum_g;
    assign b_a[2]    = vif2.sum_b;

    isp_awb_stat #(.BITS(8), .BAYER(BAYER_RGGB), .ACC_BITS(32)) u_rggb (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .vid(vif0.slave), .dbg_state(st_a[0])
    );
    isp_awb_stat #(.BITS(8), .BAYER(BAYER_BGGR), .ACC_BITS(32)) u_bggr (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .vid(vif1.slave), .dbg_state(st_a[1])
    );
    isp_awb_stat #(.BITS(8), .BAYER(BAYER_RGGB), .ACC_BITS(12)) u_sat (
        .pclk(pclk), .rst_n(rst_n), .enable(enable), .vid(vif2.slave), .dbg_state(st_a[2])
    );

    // reference model
    int          m_bayer [NDUT] = '{0, 3, 0};
    int          m_bits  [NDUT] = '{32, 32, 12};
    longint      m_cnt   [NDUT];
    longint      m_r     [NDUT];
    longint      m_g     [NDUT];
    longint      m_b     [NDUT];
    logic [127:0] last_e [NDUT];
    bit          m_armed;
    bit          m_en_lat;

    logic [127:0] exp_q0[$];
    logic [127:0] exp_q1[$];
    logic [127:0] exp_q2[$];

    function automatic logic [31:0] sat(input longint v, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    // 0 = R, 1 = G, 2 = B
    function automatic int model_colour(input int bayer, input int row, input int col);
        int r, c;
        r = row % 2;
        c = col % 2;
        case (bayer)
            0: return (r == 0 && c == 0) ? 0 : (r == 1 && c == 1) ? 2 : 1;
            1: return (r == 0 && c == 1) ? 0 : (r == 1 && c == 0) ? 2 : 1;
            2: return (r == 1 && c == 0) ? 0 : (r == 0 && c == 1) ? 2 : 1;
            default: return (r == 1 && c == 1) ? 0 : (r == 0 && c == 0) ? 2 : 1;
        endcase
    endfunction

    function automatic logic [7:0] pix_val(input int row, input int col, input int mode);
        if (mode == 1) return 8'd255;
        if (mode == 2) return 8'($urandom_range(0, 255));
        if (row % 2 == 0 && col % 2 == 0) return 8'd100;
        if (row % 2 == 1 && col % 2 == 1) return 8'd25;
        return 8'd50;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NDUT; i++) begin
            m_cnt[i] = 0;
            m_r[i]   = 0;
            m_g[i]   = 0;
            m_b[i]   = 0;
        end
    endtask

    task automatic model_pixel(input int row, input int col, input logic [7:0] v);
        if (m_armed) begin
            for (int i = 0; i < NDUT; i++) begin
                case (model_colour(m_bayer[i], row, col))
                    0: begin m_r[i] += longint'(v); m_cnt[i] += 1; end
                    1: m_g[i] += longint'(v);
                    default: m_b[i] += longint'(v);
                endcase
            end
        end
    endtask

    task automatic model_frame_end();
        logic [127:0] e;
        for (int i = 0; i < NDUT; i++) begin
            if (m_armed && m_en_lat && m_cnt[i] != 0) begin
                e = {sat(m_cnt[i], m_bits[i]), sat(m_r[i], m_bits[i]),
                     sat(m_g[i], m_bits[i]) >> 1, sat(m_b[i], m_bits[i])};
                case (i)
                    0: exp_q0.push_back(e);
                    1: exp_q1.push_back(e);
                    default: exp_q2.push_back(e);
                endcase
                last_e[i] = e;
            end
        end
        m_armed  = 1'b1;
        m_en_lat = enable;
        model_clear();
    endtask

    // driver tasks
    task automatic drive_vsync();
        model_frame_end();
        @(negedge pclk);
        drv_vsync = 1'b1;
        repeat (2) @(negedge pclk);
        drv_vsync = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic drive_line(input int row, input int cols, input int mode);
        for (int c = 0; c < cols; c++) begin
            @(negedge pclk);
            drv_href = 1'b1;
            drv_raw  = pix_val(row, c, mode);
            model_pixel(row, c, drv_raw);
        end
        @(negedge pclk);
        drv_href = 1'b0;
        drv_raw  = '0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic drive_lines(input int first_row, input int rows, input int cols,
                               input int mode);
        for (int r = first_row; r < first_row + rows; r++) drive_line(r, cols, mode);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && n < 40) begin
            @(negedge pclk);
            n++;
        end
        repeat (4) @(negedge pclk);
        checks++;
        if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_stat_done pending %0d/%0d/%0d required 0/0/0", name,
                     exp_q0.size(), exp_q1.size(), exp_q2.size());
            exp_q0.delete();
            exp_q1.delete();
            exp_q2.delete();
        end
    endtask

    // scoreboard: every stat_done pops one expectation for that instance
    logic [127:0] mon_got, mon_exp;
    bit           mon_have;
    always @(negedge pclk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < NDUT; i++) begin
                if (done_a[i] === 1'b1) begin
                    mon_got  = {cnt_a[i], r_a[i], g_a[i], b_a[i]};
                    mon_have = 1'b0;
                    mon_exp  = '0;
                    case (i)
                        0: if (exp_q0.size() > 0) begin mon_exp = exp_q0.pop_front(); mon_have = 1'b1; end
                        1: if (exp_q1.size() > 0) begin mon_exp = exp_q1.pop_front(); mon_have = 1'b1; end
                        default: if (exp_q2.size() > 0) begin mon_exp = exp_q2.pop_front(); mon_have = 1'b1; end
                    endcase
                    checks++;
                    if (!mon_have) begin
                        errors++;
                        $display("FAIL unexpected_stat_done dut%0d got %h required none", i, mon_got);
                    end else if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL stat_values dut%0d got %h required %h", i, mon_got, mon_exp);
                    end
                end
            end
        end
    end

    // scenarios
    task automatic test_reset();
        rst_n     = 1'b0;
        enable    = 1'b1;
        drv_vsync = 1'b0;
        drv_href  = 1'b0;
        drv_raw   = '0;
        m_armed   = 1'b0;
        m_en_lat  = 1'b0;
        model_clear();
        for (int i = 0; i < NDUT; i++) last_e[i] = '0;
        repeat (3) @(negedge pclk);
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({done_a[i], cnt_a[i], r_a[i], g_a[i], b_a[i]} !== 129'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got done=%b cnt=%0d r=%0d g=%0d b=%0d required 0",
                         i, done_a[i], cnt_a[i], r_a[i], g_a[i], b_a[i]);
            end
            checks++;
            if (st_a[i] !== ST_IDLE) begin
                errors++;
                $display("FAIL reset_state dut%0d got %0d required %0d", i, st_a[i], ST_IDLE);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_basic();
        logic d1, d2, d3, d4;
        drive_lines(0, 4, 4, 0);
        drive_vsync();
        drive_lines(0, 4, 4, 0);
        model_frame_end();
        @(negedge pclk);
        drv_vsync = 1'b1;
        @(negedge pclk);
        d1 = done_a[0];
        @(negedge pclk);
        d2 = done_a[0];
        drv_vsync = 1'b0;
        @(negedge pclk);
        d3 = done_a[0];
        @(negedge pclk);
        d4 = done_a[0];
        checks++;
        if ({d1, d2, d3, d4} !== 4'b0010) begin
            errors++;
            $display("FAIL basic_latency got %b required 0010", {d1, d2, d3, d4});
        end
        checks++;
        if (last_e[0] !== {32'd4, 32'd400, 32'd200, 32'd100}) begin
            errors++;
            $display("FAIL basic_model_rggb got %h required 4/400/200/100", last_e[0]);
        end
        repeat (3) @(negedge pclk);
        wait_drain("basic");
    endtask

    task automatic test_saturation();
        drive_lines(0, 10, 10, 1);
        drive_vsync();
        wait_drain("saturation");
        checks++;
        if ({cnt_a[2], r_a[2], g_a[2], b_a[2]} !== {32'd25, 32'd4095, 32'd2047, 32'd4095}) begin
            errors++;
            $display("FAIL saturation_12bit got %0d/%0d/%0d/%0d required 25/4095/2047/4095",
                     cnt_a[2], r_a[2], g_a[2], b_a[2]);
        end
    endtask

    task automatic test_odd_size();
        drive_lines(0, 3, 5, 2);
        drive_vsync();
        wait_drain("odd_size");
    endtask

    task automatic test_enable();
        enable = 1'b0;
        drive_vsync();
        drive_lines(0, 2, 4, 2);
        enable = 1'b1;
        drive_lines(2, 2, 4, 2);
        drive_vsync();
        wait_drain("enable_off");
        drive_lines(0, 4, 4, 2);
        drive_vsync();
        wait_drain("enable_on");
    endtask

    task automatic test_no_href();
        repeat (3) drive_vsync();
        wait_drain("no_href");
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({cnt_a[i], r_a[i], g_a[i], b_a[i]} !== last_e[i]) begin
                errors++;
                $display("FAIL no_href_hold dut%0d got %h required %h", i,
                         {cnt_a[i], r_a[i], g_a[i], b_a[i]}, last_e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            drive_lines(0, 4, 6, 2);
            drive_vsync();
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_mid_reset();
        drive_lines(0, 4, 4, 0);
        drive_vsync();
        wait_drain("pre_reset");
        drive_lines(0, 2, 4, 0);
        @(negedge pclk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({done_a[i], cnt_a[i], r_a[i], g_a[i], b_a[i], st_a[i]} !== 131'h0) begin
                errors++;
                $display("FAIL mid_reset_clear dut%0d got cnt=%0d r=%0d g=%0d b=%0d st=%0d required 0",
                         i, cnt_a[i], r_a[i], g_a[i], b_a[i], st_a[i]);
            end
        end
        m_armed  = 1'b0;
        m_en_lat = 1'b0;
        model_clear();
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        drive_lines(2, 2, 4, 0);
        drive_vsync();
        wait_drain("post_reset_partial");
        drive_lines(0, 4, 4, 0);
        drive_vsync();
        wait_drain("post_reset_full");
        checks++;
        if ({cnt_a[0], r_a[0], g_a[0], b_a[0]} !== {32'd4, 32'd400, 32'd200, 32'd100}) begin
            errors++;
            $display("FAIL mid_reset_report got %0d/%0d/%0d/%0d required 4/400/200/100",
                     cnt_a[0], r_a[0], g_a[0], b_a[0]);
        end
        checks++;
        if ({cnt_a[1], r_a[1], g_a[1], b_a[1]} !== {32'd4, 32'd100, 32'd200, 32'd400}) begin
            errors++;
            $display("FAIL mid_reset_report_bggr got %0d/%0d/%0d/%0d required 4/100/200/400",
                     cnt_a[1], r_a[1], g_a[1], b_a[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_odd_size();
        test_enable();
        test_no_href();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
